grad_mag_pipe: RTL

- Pipelined gradient magnitude and direction stage for the edge-detection datapath.
- Consumes signed Sobel gradient pairs (gx, gy) under valid/ready handshake.
- Produces a compile-time-selectable magnitude approximation, a 2-bit quantised edge direction for non-max suppression, and a threshold flag.
- Carries a frame-end sideband through the same pipeline.

---
 rtl/grad_mag_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/grad_mag_pipe.sv
// rtl/grad_mag_pipe.sv - two-stage gradient magnitude/direction pipeline with valid/ready flow control
module grad_mag_pipe #(
    parameter int Width = 14,
    parameter int Mode  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic signed [Width-1:0] gx_i,
    input  logic signed [Width-1:0] gy_i,
    input  logic                    last_i,
    output logic                    ready_o,
    input  logic        [Width:0]   thresh_i,
    output logic                    valid_o,
    output logic        [Width:0]   mag_o,
    output logic        [1:0]       dir_o,
    output logic                    strong_o,
    output logic                    last_o,
    input  logic                    ready_i
);

    if (Mode < 0 || Mode > 2) begin : g_bad_mode
        $error("grad_mag_pipe: Mode must be 0, 1 or 2");
    end
    if (Width < 4) begin : g_bad_width
        $error("grad_mag_pipe: Width must be at least 4");
    end

    logic             v1_q, v1_d;
    logic [Width-1:0] ax_q, ax_d, ay_q, ay_d;
    logic             sx_q, sx_d, sy_q, sy_d;
    logic             zx_q, zx_d, zy_q, zy_d;
    logic             last1_q, last1_d;

    logic             v2_q, v2_d;
    logic [Width:0]   mag_q, mag_d;
    logic [1:0]       dir_q, dir_d;
    logic             last2_q, last2_d;

    logic             en1, en2;
    logic [Width:0]   ax_w, ay_w, mx, mn, mag_c;
    logic [1:0]       dir_c;
    logic             neg_x, neg_y;

    always_comb begin
        en2 = ~v2_q | ready_i;
        en1 = ~v1_q | en2;

        // Extend before shifting so (a<<1) and the sum cannot wrap.
        ax_w = {1'b0, ax_q};
        ay_w = {1'b0, ay_q};
        mx   = (ax_w >= ay_w) ? ax_w : ay_w;
        mn   = (ax_w >= ay_w) ? ay_w : ax_w;

        if (Mode == 0) begin
            mag_c = ax_w + ay_w;
        end else if (Mode == 1) begin
            mag_c = mx;
        end else begin
            mag_c = mx + (mn >> 1);
        end

        neg_x = sx_q & ~zx_q;
        neg_y = sy_q & ~zy_q;
        if ((ay_w << 1) <= ax_w) begin
            dir_c = 2'd0;
        end else if ((ax_w << 1) <= ay_w) begin
            dir_c = 2'd2;
        end else if (neg_x == neg_y) begin
            dir_c = 2'd1;
        end else begin
            dir_c = 2'd3;
        end

        v1_d    = v1_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        zx_d    = zx_q;
        zy_d    = zy_q;
        last1_d = last1_q;
        v2_d    = v2_q;
        mag_d   = mag_q;
        dir_d   = dir_q;
        last2_d = last2_q;

        if (en1) begin
            v1_d    = valid_i;
            // Negating the most negative value lands on 2^(Width-1), still representable unsigned.
            ax_d    = gx_i[Width-1] ? $unsigned(-gx_i) : $unsigned(gx_i);
            ay_d    = gy_i[Width-1] ? $unsigned(-gy_i) : $unsigned(gy_i);
            sx_d    = gx_i[Width-1];
            sy_d    = gy_i[Width-1];
            zx_d    = (gx_i == '0);
            zy_d    = (gy_i == '0);
            last1_d = last_i;
        end
        if (en2) begin
            v2_d    = v1_q;
            mag_d   = mag_c;
            dir_d   = dir_c;
            last2_d = last1_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            zx_q    <= 1'b0;
            zy_q    <= 1'b0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            mag_q   <= '0;
            dir_q   <= 2'd0;
            last2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            zx_q    <= zx_d;
            zy_q    <= zy_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            mag_q   <= mag_d;
            dir_q   <= dir_d;
            last2_q <= last2_d;
        end
    end

    assign ready_o  = en1;
    assign valid_o  = v2_q;
    assign mag_o    = mag_q;
    assign dir_o    = dir_q;
    assign last_o   = last2_q;
    assign strong_o = (mag_q >= thresh_i);

endmodule
